// File: rtl/ex_alu_rs_pkg.sv
// ex_alu_rs_pkg: shared types and constants for the ALU reservation station.
//   addr_t/word_t/regtag_t/regaddr_t/sinst_t - common datapath types
//   UNLOCKED                                 - tag value meaning "operand present"
//   TAG_W / OP_W                             - default tag and opcode widths
//   EX_RS_ENTRY_FIELDS(OPW, TAGW)            - field layout of one RS entry
//                                              (valid and age rank kept apart)

`define EX_RS_ENTRY_FIELDS(OPW, TAGW) \
    logic [(OPW)-1:0]  op;     \
    addr_t             pc;     \
    regaddr_t          target; \
    logic [(TAGW)-1:0] tagx;   \
    logic [(TAGW)-1:0] tagy;   \
    logic [(TAGW)-1:0] tagw;   \
    word_t             datax;  \
    word_t             datay;

package ex_alu_rs_pkg;

    localparam int TAG_W    = 3;
    localparam int OP_W     = 6;
    localparam int UNLOCKED = 0;

    typedef logic [31:0]      addr_t;
    typedef logic [31:0]      word_t;
    typedef logic [TAG_W-1:0] regtag_t;
    typedef logic [4:0]       regaddr_t;
    typedef logic [OP_W-1:0]  sinst_t;

endpackage

// File: rtl/ex_alu_rs_if.sv
// ex_alu_rs_if: dispatch-to-reservation-station enqueue bus.
//   master (dispatch): drives in_valid and the in_* op fields, samples in_ready
//   slave  (RS)      : samples the op fields, drives in_ready

interface ex_alu_rs_if #(
    parameter int TAG_W = ex_alu_rs_pkg::TAG_W,
    parameter int OP_W  = ex_alu_rs_pkg::OP_W
);
    import ex_alu_rs_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    addr_t            in_pc;
    regaddr_t         in_target;
    logic [TAG_W-1:0] in_tagx;
    logic [TAG_W-1:0] in_tagy;
    logic [TAG_W-1:0] in_tagw;
    word_t            in_datax;
    word_t            in_datay;

    modport master (
        output in_valid, in_op, in_pc, in_target, in_tagx, in_tagy, in_tagw,
               in_datax, in_datay,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_pc, in_target, in_tagx, in_tagy, in_tagw,
               in_datax, in_datay,
        output in_ready
    );

endinterface

// File: rtl/ex_rs_pick.sv
// ex_rs_pick: combinational oldest-ready selector.
//   ready   in  DEPTH        per-entry ready flags
//   age     in  DEPTH x AW   per-entry age rank (0 = oldest)
//   grant   out DEPTH        one-hot grant of the ready entry with smallest rank
//   gnt_vld out 1            at least one entry is ready

module ex_rs_pick #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic [DEPTH-1:0] ready,
    input  logic [AW-1:0]    age [DEPTH],
    output logic [DEPTH-1:0] grant,
    output logic             gnt_vld
);
    import ex_alu_rs_pkg::*;

    logic [AW-1:0] best_age;
    logic [AW-1:0] best_idx;

    always_comb begin
        grant    = '0;
        gnt_vld  = 1'b0;
        best_age = '0;
        best_idx = '0;
        // Ranks of valid entries are unique; a tie could only occur on bad
        // state and then resolves to the lowest index.
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && (!gnt_vld || age[i] < best_age)) begin
                gnt_vld  = 1'b1;
                best_age = age[i];
                best_idx = AW'(i);
            end
        end
        if (gnt_vld) grant[best_idx] = 1'b1;
    end

endmodule

// File: rtl/ex_alu_rs.sv
// ex_alu_rs: reservation station feeding the integer ALU execute stage.
//   clk, rst_n       clock, asynchronous active-low reset
//   rdy              global enable; 0 holds every register
//   enq (slave)      enqueue bus from dispatch (in_valid/in_ready + op fields)
//   cdb_en/tag/data  writeback broadcast snooped for operand wakeup
//   flush_in         taken-jump flush from the ALU
//   alu_*_out        registered issue bundle, tags always UNLOCKED
//   count_out        number of occupied entries

module ex_alu_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = ex_alu_rs_pkg::TAG_W,
    parameter int OP_W  = ex_alu_rs_pkg::OP_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    ex_alu_rs_if.slave               enq,
    input  logic                     cdb_en,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [31:0]              cdb_data,
    input  logic                     flush_in,
    output logic                     alu_busy_out,
    output logic [OP_W-1:0]          alu_op_out,
    output logic [31:0]              alu_pc_out,
    output logic [4:0]               alu_target_out,
    output logic [TAG_W-1:0]         alu_tagx_out,
    output logic [TAG_W-1:0]         alu_tagy_out,
    output logic [TAG_W-1:0]         alu_tagw_out,
    output logic [31:0]              alu_datax_out,
    output logic [31:0]              alu_datay_out,
    output logic [$clog2(DEPTH):0]   count_out
);
    import ex_alu_rs_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [TAG_W-1:0] UNL = TAG_W'(UNLOCKED);

    typedef struct packed {
        `EX_RS_ENTRY_FIELDS(OP_W, TAG_W)
    } rs_entry_t;

    rs_entry_t        ent_p0 [DEPTH];
    logic [DEPTH-1:0] valid_p0;
    logic [AW-1:0]    age_p0 [DEPTH];
    logic [CW-1:0]    count_p0;

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] grant;
    logic             gnt_vld;
    logic [AW-1:0]    iss_idx;
    logic [AW-1:0]    iss_age;
    logic [AW-1:0]    free_idx;
    logic [AW-1:0]    enq_age;
    logic             cdb_hit;
    logic             do_enq;
    logic             do_iss;
    rs_entry_t        enq_ent;

    assign enq.in_ready = (count_p0 < CW'(DEPTH));
    assign count_out    = count_p0;
    assign cdb_hit      = cdb_en && (cdb_tag != UNL);
    assign do_enq       = rdy && !flush_in && enq.in_valid && enq.in_ready;
    assign do_iss       = rdy && !flush_in && gnt_vld;
    // With a same-cycle issue the newcomer slots in behind the survivors.
    assign enq_age      = AW'(count_p0 - CW'(do_iss));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid_p0[i] && (ent_p0[i].tagx == UNL) &&
                       (ent_p0[i].tagy == UNL) && (ent_p0[i].tagw == UNL);
        end
    end

    ex_rs_pick #(.DEPTH(DEPTH), .AW(AW)) u_pick (
        .ready   (ready),
        .age     (age_p0),
        .grant   (grant),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        iss_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) iss_idx = AW'(i);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_p0[i]) free_idx = AW'(i);
        end
        iss_age = age_p0[iss_idx];
    end

    // Incoming op with the broadcast applied, so a tag produced in the
    // enqueue cycle is never missed.
    always_comb begin
        enq_ent.op     = enq.in_op;
        enq_ent.pc     = enq.in_pc;
        enq_ent.target = enq.in_target;
        enq_ent.tagx   = enq.in_tagx;
        enq_ent.tagy   = enq.in_tagy;
        enq_ent.tagw   = enq.in_tagw;
        enq_ent.datax  = enq.in_datax;
        enq_ent.datay  = enq.in_datay;
        if (cdb_hit && enq.in_tagx == cdb_tag) begin
            enq_ent.tagx  = UNL;
            enq_ent.datax = cdb_data;
        end
        if (cdb_hit && enq.in_tagy == cdb_tag) begin
            enq_ent.tagy  = UNL;
            enq_ent.datay = cdb_data;
        end
        if (cdb_hit && enq.in_tagw == cdb_tag) enq_ent.tagw = UNL;
    end

    // ---- stage p0: entry occupancy and age ranks ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_p0 <= '0;
            count_p0 <= '0;
            for (int i = 0; i < DEPTH; i++) age_p0[i] <= '0;
        end else if (rdy) begin
            if (flush_in) begin
                valid_p0 <= '0;
                count_p0 <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (do_iss && valid_p0[i] && age_p0[i] > iss_age)
                        age_p0[i] <= age_p0[i] - AW'(1);
                end
                if (do_iss) valid_p0[iss_idx] <= 1'b0;
                if (do_enq) begin
                    valid_p0[free_idx] <= 1'b1;
                    age_p0[free_idx]   <= enq_age;
                end
                count_p0 <= count_p0 + CW'(do_enq) - CW'(do_iss);
            end
        end
    end

    // Entry payload; qualified by valid_p0, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rdy && !flush_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_enq && free_idx == AW'(i)) begin
                    ent_p0[i] <= enq_ent;
                end else if (cdb_hit && valid_p0[i]) begin
                    if (ent_p0[i].tagx == cdb_tag) begin
                        ent_p0[i].tagx  <= UNL;
                        ent_p0[i].datax <= cdb_data;
                    end
                    if (ent_p0[i].tagy == cdb_tag) begin
                        ent_p0[i].tagy  <= UNL;
                        ent_p0[i].datay <= cdb_data;
                    end
                    if (ent_p0[i].tagw == cdb_tag) ent_p0[i].tagw <= UNL;
                end
            end
        end
    end

    // ---- stage p1: issue bundle to the ALU ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_busy_out   <= 1'b0;
            alu_op_out     <= '0;
            alu_pc_out     <= '0;
            alu_target_out <= '0;
            alu_tagx_out   <= UNL;
            alu_tagy_out   <= UNL;
            alu_tagw_out   <= UNL;
            alu_datax_out  <= '0;
            alu_datay_out  <= '0;
        end else if (rdy) begin
            alu_busy_out <= do_iss;
            if (do_iss) begin
                alu_op_out     <= ent_p0[iss_idx].op;
                alu_pc_out     <= ent_p0[iss_idx].pc;
                alu_target_out <= ent_p0[iss_idx].target;
                alu_tagx_out   <= ent_p0[iss_idx].tagx;
                alu_tagy_out   <= ent_p0[iss_idx].tagy;
                alu_tagw_out   <= ent_p0[iss_idx].tagw;
                alu_datax_out  <= ent_p0[iss_idx].datax;
                alu_datay_out  <= ent_p0[iss_idx].datay;
            end
        end
    end

endmodule

// File: tb/tb_ex_alu_rs.sv
// tb_ex_alu_rs: directed bench for ex_alu_rs with hand-computed expectations.

module tb_ex_alu_rs;

    localparam int TAG_W = 3;
    localparam int OP_W  = 6;
    localparam logic [OP_W-1:0] OP_ADD = 6'h01;
    localparam logic [OP_W-1:0] OP_SUB = 6'h02;
    localparam logic [OP_W-1:0] OP_OR  = 6'h03;

    logic              clk;
    logic              rst_n;
    logic              rdy;
    logic              cdb_en;
    logic [TAG_W-1:0]  cdb_tag;
    logic [31:0]       cdb_data;
    logic              flush_in;
    logic              alu_busy_out;
    logic [OP_W-1:0]   alu_op_out;
    logic [31:0]       alu_pc_out;
    logic [4:0]        alu_target_out;
    logic [TAG_W-1:0]  alu_tagx_out;
    logic [TAG_W-1:0]  alu_tagy_out;
    logic [TAG_W-1:0]  alu_tagw_out;
    logic [31:0]       alu_datax_out;
    logic [31:0]       alu_datay_out;
    logic [2:0]        count_out;

    int n_tests = 0;
    int n_fail  = 0;

    ex_alu_rs_if #(.TAG_W(TAG_W), .OP_W(OP_W)) enq_if ();

    ex_alu_rs #(.DEPTH(4), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .enq            (enq_if),
        .cdb_en         (cdb_en),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .flush_in       (flush_in),
        .alu_busy_out   (alu_busy_out),
        .alu_op_out     (alu_op_out),
        .alu_pc_out     (alu_pc_out),
        .alu_target_out (alu_target_out),
        .alu_tagx_out   (alu_tagx_out),
        .alu_tagy_out   (alu_tagy_out),
        .alu_tagw_out   (alu_tagw_out),
        .alu_datax_out  (alu_datax_out),
        .alu_datay_out  (alu_datay_out),
        .count_out      (count_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_if.in_valid = 1'b0;
        cdb_en          = 1'b0;
        cdb_tag         = '0;
        cdb_data        = '0;
        flush_in        = 1'b0;
    endtask

    task automatic put(input logic [OP_W-1:0] op, input logic [31:0] pc,
                       input logic [4:0] tgt, input logic [TAG_W-1:0] tx,
                       input logic [TAG_W-1:0] ty, input logic [TAG_W-1:0] tw,
                       input logic [31:0] dx, input logic [31:0] dy);
        enq_if.in_valid  = 1'b1;
        enq_if.in_op     = op;
        enq_if.in_pc     = pc;
        enq_if.in_target = tgt;
        enq_if.in_tagx   = tx;
        enq_if.in_tagy   = ty;
        enq_if.in_tagw   = tw;
        enq_if.in_datax  = dx;
        enq_if.in_datay  = dy;
    endtask

    task automatic bcast(input logic [TAG_W-1:0] t, input logic [31:0] d);
        cdb_en   = 1'b1;
        cdb_tag  = t;
        cdb_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        idle();
        put(6'h0, 32'h0, 5'h0, 3'h0, 3'h0, 3'h0, 32'h0, 32'h0);
        enq_if.in_valid = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_busy",  64'(alu_busy_out), 64'h0);
        chk("rst_count", 64'(count_out), 64'h0);
        chk("rst_ready", 64'(enq_if.in_ready), 64'h1);
        chk("rst_data",  {alu_datax_out, alu_datay_out}, 64'h0);
        chk("rst_tags",  {alu_tagx_out, alu_tagy_out, alu_tagw_out}, 64'h0);
        rst_n = 1'b1;
        step();

        // Single ready ADD: 2 edges to issue
        put(OP_ADD, 32'h100, 5'd3, 3'd0, 3'd0, 3'd0, 32'd5, 32'd7);
        step();
        idle();
        chk("add_e1_busy",  64'(alu_busy_out), 64'h0);
        chk("add_e1_count", 64'(count_out), 64'h1);
        step();
        chk("add_busy",  64'(alu_busy_out), 64'h1);
        chk("add_op",    64'(alu_op_out), 64'(OP_ADD));
        chk("add_x_y",   {alu_datax_out, alu_datay_out}, {32'd5, 32'd7});
        chk("add_tgtpc", {27'h0, alu_target_out, alu_pc_out}, {27'h0, 5'd3, 32'h100});
        chk("add_tags",  64'({alu_tagx_out, alu_tagy_out, alu_tagw_out}), 64'h0);
        chk("add_count", 64'(count_out), 64'h0);
        step();
        chk("add_after", 64'(alu_busy_out), 64'h0);

        // SUB waits on tag 2; younger OR is ready and issues first
        put(OP_SUB, 32'h200, 5'd4, 3'd2, 3'd0, 3'd0, 32'h0, 32'h1);
        step();
        put(OP_OR, 32'h204, 5'd5, 3'd0, 3'd0, 3'd0, 32'hF0, 32'h0F);
        step();
        idle();
        bcast(3'd2, 32'h10);
        step();
        idle();
        chk("or_busy",  64'(alu_busy_out), 64'h1);
        chk("or_op",    64'(alu_op_out), 64'(OP_OR));
        chk("or_x",     64'(alu_datax_out), 64'hF0);
        chk("or_count", 64'(count_out), 64'h1);
        step();
        chk("sub_busy", 64'(alu_busy_out), 64'h1);
        chk("sub_op",   64'(alu_op_out), 64'(OP_SUB));
        chk("sub_x_y",  {alu_datax_out, alu_datay_out}, {32'h10, 32'h1});
        chk("sub_count", 64'(count_out), 64'h0);
        step();
        chk("sub_after", 64'(alu_busy_out), 64'h0);

        // Fill all entries, all blocked on tag 5
        for (int i = 0; i < 4; i++) begin
            put(OP_W'(6'h10 + i), 32'h300 + 32'(i * 4), 5'(i), 3'd5, 3'd0, 3'd0,
                32'h0, 32'(i));
            step();
        end
        idle();
        chk("full_ready", 64'(enq_if.in_ready), 64'h0);
        chk("full_count", 64'(count_out), 64'h4);
        // Enqueue attempt while full must be dropped
        put(6'h3F, 32'h0, 5'd0, 3'd0, 3'd0, 3'd0, 32'h0, 32'h0);
        bcast(3'd5, 32'h55);
        step();
        idle();
        chk("wake_count", 64'(count_out), 64'h4);
        chk("wake_busy",  64'(alu_busy_out), 64'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fill_busy",  64'(alu_busy_out), 64'h1);
            chk("fill_op",    64'(alu_op_out), 64'(6'h10 + i));
            chk("fill_x_y",   {alu_datax_out, alu_datay_out}, {32'h55, 32'(i)});
            chk("fill_count", 64'(count_out), 64'(3 - i));
            if (i == 0) chk("fill_ready", 64'(enq_if.in_ready), 64'h1);
        end
        step();
        chk("fill_after", 64'(alu_busy_out), 64'h0);

        // Enqueue bypass: tag broadcast in the enqueue cycle
        put(OP_ADD, 32'h400, 5'd7, 3'd0, 3'd4, 3'd0, 32'h11, 32'h0);
        bcast(3'd4, 32'hAB);
        step();
        idle();
        chk("byp_e1_busy", 64'(alu_busy_out), 64'h0);
        step();
        chk("byp_busy", 64'(alu_busy_out), 64'h1);
        chk("byp_x_y",  {alu_datax_out, alu_datay_out}, {32'h11, 32'hAB});
        step();

        // Flush with three pending (one ready) plus an incoming op
        put(OP_SUB, 32'h500, 5'd1, 3'd6, 3'd0, 3'd0, 32'h0, 32'h0);
        step();
        put(OP_SUB, 32'h504, 5'd2, 3'd6, 3'd0, 3'd0, 32'h0, 32'h0);
        step();
        put(OP_OR, 32'h508, 5'd3, 3'd0, 3'd0, 3'd0, 32'h1, 32'h2);
        step();
        chk("pre_fl_count", 64'(count_out), 64'h3);
        put(OP_ADD, 32'h50C, 5'd4, 3'd0, 3'd0, 3'd0, 32'h3, 32'h4);
        flush_in = 1'b1;
        step();
        idle();
        chk("fl_count", 64'(count_out), 64'h0);
        chk("fl_busy",  64'(alu_busy_out), 64'h0);
        step();
        chk("fl_drop_busy",  64'(alu_busy_out), 64'h0);
        chk("fl_drop_count", 64'(count_out), 64'h0);

        // rdy=0 holds everything
        put(6'h21, 32'h600, 5'd9, 3'd0, 3'd0, 3'd0, 32'h33, 32'h44);
        step();
        rdy = 1'b0;
        put(6'h22, 32'h604, 5'd8, 3'd0, 3'd0, 3'd0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_busy",  64'(alu_busy_out), 64'h0);
            chk("hold_count", 64'(count_out), 64'h1);
        end
        idle();
        rdy = 1'b1;
        step();
        chk("rdy_busy", 64'(alu_busy_out), 64'h1);
        chk("rdy_op",   64'(alu_op_out), 64'h21);
        chk("rdy_x",    64'(alu_datax_out), 64'h33);
        rdy = 1'b0;
        step();
        chk("hold_issue_busy", 64'(alu_busy_out), 64'h1);
        rdy = 1'b1;
        step();
        chk("rdy_after", 64'(alu_busy_out), 64'h0);

        // Asynchronous reset mid-stream
        put(OP_ADD, 32'h700, 5'd1, 3'd0, 3'd0, 3'd0, 32'h77, 32'h88);
        step();
        put(OP_SUB, 32'h704, 5'd2, 3'd0, 3'd0, 3'd0, 32'h99, 32'hAA);
        step();
        idle();
        chk("pre_rst_busy",  64'(alu_busy_out), 64'h1);
        chk("pre_rst_count", 64'(count_out), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  64'(alu_busy_out), 64'h0);
        chk("mid_rst_count", 64'(count_out), 64'h0);
        chk("mid_rst_data",  {alu_datax_out, alu_datay_out}, 64'h0);
        chk("mid_rst_op",    64'(alu_op_out), 64'h0);
        #1;
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_busy",  64'(alu_busy_out), 64'h0);
        chk("post_rst_count", 64'(count_out), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
